// File: rtl/register_ffd_pkg.sv
// Shared defaults for the parallel-load D flip-flop register.
package register_ffd_pkg;
  localparam int REG_WIDTH_DEFAULT       = 4;
  localparam int REG_RESET_VALUE_DEFAULT = 0;

  typedef logic [REG_WIDTH_DEFAULT-1:0] reg_word_t;
endpackage

// File: rtl/register_ffd_4bits_ffd_cell.sv
// One-bit D flip-flop with synchronous active-high clear and load enable.
module ffd_cell #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic clear,
  input  logic d,
  input  logic en,
  output logic q
);
  // Clear wins over enable so a cleared register never sees stale data.
  always_ff @(posedge clk) begin
    if (clear)   q <= RST_VAL;
    else if (en) q <= d;
  end
endmodule

// File: rtl/register_ffd_4bits.sv
// WIDTH-bit parallel-load register built from per-bit ffd_cell lanes.
// Define REGISTER_FFD_LOAD_EN to add the load-enable input; otherwise every non-clear edge loads.
module register_ffd_4bits
  import register_ffd_pkg::*;
#(
  parameter int               WIDTH       = REG_WIDTH_DEFAULT,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(REG_RESET_VALUE_DEFAULT)
) (
  input  logic             clk,
  input  logic             clear,
`ifdef REGISTER_FFD_LOAD_EN
  input  logic             load,
`endif
  input  logic [WIDTH-1:0] In,
  output logic [WIDTH-1:0] An
);
  logic en;

`ifdef REGISTER_FFD_LOAD_EN
  assign en = load;
`else
  assign en = 1'b1;
`endif

  // Bits are independent; An comes straight from the cell Q outputs.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    ffd_cell #(.RST_VAL(RESET_VALUE[i])) u_cell (
      .clk  (clk),
      .clear(clear),
      .d    (In[i]),
      .en   (en),
      .q    (An[i])
    );
  end
endmodule

// File: tb/tb_register_ffd_4bits.sv
// Scoreboard bench for register_ffd_4bits: driver queues expected An, monitor checks at negedge.
module tb_register_ffd_4bits;
  import register_ffd_pkg::*;

  typedef struct {
    string     name;
    reg_word_t exp;
  } sb_ent_t;

  logic      clk_tb = 1'b0;
  logic      clear  = 1'b0;
  logic      load   = 1'b1;
  reg_word_t In     = '0;
  reg_word_t An;

  sb_ent_t sb[$];
  int      n_chk  = 0;
  int      n_fail = 0;

  register_ffd_4bits #(.WIDTH(4), .RESET_VALUE(4'b0000)) dut (
    .clk  (clk_tb),
    .clear(clear),
`ifdef REGISTER_FFD_LOAD_EN
    .load (load),
`endif
    .In   (In),
    .An   (An)
  );

  always #5 clk_tb = ~clk_tb;

  // Inputs change 1 time unit after the edge, so every negedge check also
  // confirms An ignored the mid-cycle input change.
  task automatic cyc(input string nm, input logic c, input logic l,
                     input reg_word_t d, input reg_word_t e);
    sb_ent_t ent;
    clear = c;
    load  = l;
    In    = d;
    @(posedge clk_tb);
    ent.name = nm;
    ent.exp  = e;
    sb.push_back(ent);
    #1;
  endtask

  initial begin : monitor
    sb_ent_t ent;
    forever begin
      @(negedge clk_tb);
      if (sb.size() > 0) begin
        ent = sb.pop_front();
        n_chk++;
        if (An !== ent.exp) begin
          n_fail++;
          $display("FAIL %s: An=%b expected %b", ent.name, An, ent.exp);
        end
      end
    end
  end

  initial begin : stim
    reg_word_t r;
    @(posedge clk_tb);
    #1;

    // Reset with all-ones input, then clear held while In varies
    cyc("reset_ones", 1'b1, 1'b1, 4'b1111, 4'b0000);
    cyc("reset_hold1", 1'b1, 1'b1, 4'b0011, 4'b0000);
    cyc("reset_hold2", 1'b1, 1'b1, 4'b1010, 4'b0000);
    cyc("reset_hold3", 1'b1, 1'b1, 4'b0101, 4'b0000);

    // Basic load, first edge after clear loads normally
    cyc("load_0101", 1'b0, 1'b1, 4'b0101, 4'b0101);
    cyc("load_1010", 1'b0, 1'b1, 4'b1010, 4'b1010);

    // Hold: In moves to 1100 right after 0011 is captured
    cyc("hold_0011", 1'b0, 1'b1, 4'b0011, 4'b0011);
    cyc("hold_1100", 1'b0, 1'b1, 4'b1100, 4'b1100);

    // Clear glitch between edges must not disturb An
    clear = 1'b1;
    #2;
    cyc("clr_glitch", 1'b0, 1'b1, 4'b1110, 4'b1110);

    // Random stream then mid-stream clear and recovery
    for (int i = 0; i < 10; i++) begin
      r = reg_word_t'($urandom_range(0, 15));
      cyc("rand_load", 1'b0, 1'b1, r, r);
    end
    cyc("mid_clear", 1'b1, 1'b1, 4'b1001, 4'b0000);
    cyc("post_clear", 1'b0, 1'b1, 4'b0110, 4'b0110);

    // Full sweep of input codes
    for (int v = 0; v < 16; v++)
      cyc("sweep", 1'b0, 1'b1, reg_word_t'(v), reg_word_t'(v));

`ifdef REGISTER_FFD_LOAD_EN
    cyc("gate_set", 1'b0, 1'b1, 4'b0111, 4'b0111);
    cyc("gate_hold1", 1'b0, 1'b0, 4'b1000, 4'b0111);
    cyc("gate_hold2", 1'b0, 1'b0, 4'b1000, 4'b0111);
    cyc("gate_load", 1'b0, 1'b1, 4'b1000, 4'b1000);
    cyc("gate_clear", 1'b1, 1'b0, 4'b1000, 4'b0000);
    cyc("gate_hold0", 1'b0, 1'b0, 4'b0101, 4'b0000);
`endif

    // Drain the scoreboard, bounded
    for (int k = 0; k < 4 && sb.size() > 0; k++) @(negedge clk_tb);
    #1;
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
